melody_seq: RTL and testbench

MELODY_SEQ -- requirements
Module: melody_seq

---
 rtl/melody_seq.sv | 219 +++++++++++++++++++++
 tb/tb_melody_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_seq.sv
//------------------------------------------------------------------------------
// melody_seq
//   Plays a short melody stored in a small writable note table. Each entry
//   holds a half-period (HP, in iCLK cycles; 0 = rest) and a duration (DUR, in
//   ticks of TICK_DIV cycles; 0 behaves as 1). The output is a square wave
//   toggling every HP cycles while a note sounds.
//
// Ports
//   iCLK      clock, all state changes on the rising edge
//   iRST      asynchronous active-high reset (also clears the note table)
//   iWR_EN    note-table write strobe
//   iWR_ADDR  note-table write address (addresses >= STEPS are dropped)
//   iWR_HP    half-period to write
//   iWR_DUR   duration to write
//   iLEN      number of active steps, 1..STEPS
//   iLOOP     1 = restart at step 0 after the last step
//   iSTART    start request (level, honoured only in IDLE with a legal iLEN)
//   iSTOP     abort request (level, wins over iSTART)
//   oSOUND    square-wave audio output
//   oBUSY     high while playing
//   oDONE     one-cycle pulse after the natural end of a non-looped melody
//   oSTEP     index of the step currently playing
//------------------------------------------------------------------------------
module melody_seq #(
   parameter int TICK_DIV = 6_250_000,
   parameter int STEPS    = 8,
   parameter int HP_W     = 21,
   parameter int DUR_W    = 4,
   localparam int AW      = $clog2(STEPS)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iWR_EN,
   input  logic [AW-1:0]    iWR_ADDR,
   input  logic [HP_W-1:0]  iWR_HP,
   input  logic [DUR_W-1:0] iWR_DUR,
   input  logic [AW:0]      iLEN,
   input  logic             iLOOP,
   input  logic             iSTART,
   input  logic             iSTOP,
   output logic             oSOUND,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [AW-1:0]    oSTEP
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0]    STEP_LAST = AW'(STEPS - 1);
   localparam logic [AW:0]      LEN_MAX   = (AW+1)'(STEPS);
   localparam logic [AW:0]      LEN_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0]    STEP_ONE  = AW'(1);
   localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
   localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
   localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t           stateReg, stateNext;
   logic [AW-1:0]    stepReg, stepNext;
   logic [TW-1:0]    tickReg, tickNext;
   logic [DUR_W-1:0] durReg, durNext;
   logic [HP_W-1:0]  toneReg, toneNext;
   logic             soundReg, soundNext;
   logic             doneReg, doneNext;

   //---------------------------------------------------------------------------
   // Note table: plain registers so reset can clear every entry and the
   // playing entry can be read combinationally.
   //---------------------------------------------------------------------------
   logic [HP_W-1:0]  hpTable  [STEPS];
   logic [DUR_W-1:0] durTable [STEPS];
   logic [STEPS-1:0] wrSel;

   genvar gi;
   generate
      for (gi = 0; gi < STEPS; gi++) begin : gWrSel
         // No entry decodes an out-of-range address, so such writes vanish.
         assign wrSel[gi] = iWR_EN && (iWR_ADDR == AW'(gi));
      end
   endgenerate

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int i = 0; i < STEPS; i++) begin
            hpTable[i]  <= '0;
            durTable[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STEPS; i++) begin
            if (wrSel[i]) begin
               hpTable[i]  <= iWR_HP;
               durTable[i] <= iWR_DUR;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Decode of the playing entry
   //---------------------------------------------------------------------------
   logic [HP_W-1:0]  curHp;
   logic [DUR_W-1:0] curDur;
   logic [DUR_W-1:0] durLast;
   logic [AW:0]      stepPlus;
   logic             lenOk, tickHit, stepEnd, lastStep, toneHit;

   assign curHp    = hpTable[stepReg];
   assign curDur   = durTable[stepReg];
   assign durLast  = (curDur == '0) ? '0 : curDur - DUR_ONE;
   assign lenOk    = (iLEN != '0) && (iLEN <= LEN_MAX);
   assign tickHit  = (tickReg == TICK_LAST);
   // '>=' rather than '==' so a rewrite of the playing entry to a shorter
   // duration or half-period cannot leave a counter stranded past its limit.
   assign stepEnd  = tickHit && (durReg >= durLast);
   assign toneHit  = (toneReg >= curHp - HP_ONE);
   assign stepPlus = {1'b0, stepReg} + LEN_ONE;
   // The STEP_LAST term keeps the index inside the table if iLEN is changed
   // to something illegal mid-melody.
   assign lastStep = (stepPlus >= iLEN) || (stepReg == STEP_LAST);

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         stateReg <= IDLE;
         stepReg  <= '0;
         tickReg  <= '0;
         durReg   <= '0;
         toneReg  <= '0;
         soundReg <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         stepReg  <= stepNext;
         tickReg  <= tickNext;
         durReg   <= durNext;
         toneReg  <= toneNext;
         soundReg <= soundNext;
         doneReg  <= doneNext;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      stateNext = stateReg;
      stepNext  = stepReg;
      tickNext  = tickReg;
      durNext   = durReg;
      toneNext  = toneReg;
      soundNext = soundReg;
      doneNext  = 1'b0;

      case (stateReg)
         IDLE: begin
            soundNext = 1'b0;
            if (iSTART && !iSTOP && lenOk) begin
               stateNext = PLAY;
               stepNext  = '0;
               tickNext  = '0;
               durNext   = '0;
               toneNext  = '0;
            end
         end

         PLAY: begin
            if (iSTOP) begin
               // Abort keeps the step index, clears everything else.
               stateNext = IDLE;
               tickNext  = '0;
               durNext   = '0;
               toneNext  = '0;
               soundNext = 1'b0;
            end else begin
               tickNext = tickHit ? '0 : tickReg + TICK_ONE;

               if (curHp == '0) begin
                  toneNext  = '0;
                  soundNext = 1'b0;
               end else if (toneHit) begin
                  toneNext  = '0;
                  soundNext = !soundReg;
               end else begin
                  toneNext  = toneReg + HP_ONE;
               end

               if (stepEnd) begin
                  // Every step change restarts the note silent and in phase.
                  durNext   = '0;
                  toneNext  = '0;
                  soundNext = 1'b0;
                  if (!lastStep) begin
                     stepNext = stepReg + STEP_ONE;
                  end else if (iLOOP) begin
                     stepNext = '0;
                  end else begin
                     stateNext = IDLE;
                     tickNext  = '0;
                     doneNext  = 1'b1;
                  end
               end else if (tickHit) begin
                  durNext = durReg + DUR_ONE;
               end
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   assign oSOUND = soundReg;
   assign oBUSY  = (stateReg == PLAY);
   assign oDONE  = doneReg;
   assign oSTEP  = stepReg;

endmodule

// File: tb/tb_melody_seq.sv
//------------------------------------------------------------------------------
// tb_melody_seq
//   Directed bench for melody_seq with TICK_DIV=4, STEPS=4. Inputs change and
//   outputs are observed on the falling edge; "cycle c" is the c-th falling
//   edge after the rising edge that accepted iSTART.
//------------------------------------------------------------------------------
module tb_melody_seq;

   logic       iCLK = 1'b0;
   logic       iRST;
   logic       iWR_EN;
   logic [1:0] iWR_ADDR;
   logic [7:0] iWR_HP;
   logic [3:0] iWR_DUR;
   logic [2:0] iLEN;
   logic       iLOOP;
   logic       iSTART;
   logic       iSTOP;
   logic       oSOUND;
   logic       oBUSY;
   logic       oDONE;
   logic [1:0] oSTEP;

   int checks = 0;
   int errors = 0;

   melody_seq #(
      .TICK_DIV (4),
      .STEPS    (4),
      .HP_W     (8),
      .DUR_W    (4)
   ) dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iWR_EN   (iWR_EN),
      .iWR_ADDR (iWR_ADDR),
      .iWR_HP   (iWR_HP),
      .iWR_DUR  (iWR_DUR),
      .iLEN     (iLEN),
      .iLOOP    (iLOOP),
      .iSTART   (iSTART),
      .iSTOP    (iSTOP),
      .oSOUND   (oSOUND),
      .oBUSY    (oBUSY),
      .oDONE    (oDONE),
      .oSTEP    (oSTEP)
   );

   always #5 iCLK = ~iCLK;

   task automatic writeNote(input logic [1:0] addr, input logic [7:0] hp, input logic [3:0] dur);
      iWR_EN   = 1'b1;
      iWR_ADDR = addr;
      iWR_HP   = hp;
      iWR_DUR  = dur;
      @(negedge iCLK);
      iWR_EN   = 1'b0;
      $display("write addr=%0d hp=%0d dur=%0d", addr, hp, dur);
   endtask

   task automatic startPulse();
      iSTART = 1'b1;
      @(negedge iCLK);
      iSTART = 1'b0;
   endtask

   task automatic test_reset();
      iRST = 1'b1; iWR_EN = 1'b0; iWR_ADDR = '0; iWR_HP = '0; iWR_DUR = '0;
      iLEN = 3'd3; iLOOP = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
      @(negedge iCLK);
      @(negedge iCLK);
      checks++;
      if (oBUSY !== 1'b0 || oSOUND !== 1'b0 || oDONE !== 1'b0 || oSTEP !== 2'd0) begin
         errors++;
         $display("FAIL reset busy/sound/done/step got %b%b%b/%0d exp 000/0", oBUSY, oSOUND, oDONE, oSTEP);
      end
      iRST = 1'b0;
      @(negedge iCLK);
      $display("reset: busy=%b sound=%b done=%b step=%0d", oBUSY, oSOUND, oDONE, oSTEP);
   endtask

   // Table {(3,2),(0,1),(5,1),(2,1)}, iLEN=3, no loop.
   task automatic test_oneshot();
      logic [0:15] snd;
      logic [1:0]  expStep;
      int busyCnt, doneCnt;
      snd = 16'b0001_1100_0000_0000;
      busyCnt = 0; doneCnt = 0;
      iLEN = 3'd3; iLOOP = 1'b0;
      startPulse();
      for (int c = 0; c < 24; c++) begin
         expStep = (c < 8) ? 2'd0 : (c < 12) ? 2'd1 : 2'd2;
         if (c < 16) begin
            checks++;
            if (oSOUND !== snd[c]) begin
               errors++;
               $display("FAIL oneshot sound c=%0d got %b exp %b", c, oSOUND, snd[c]);
            end
         end
         if (c < 18) begin
            checks++;
            if (oSTEP !== expStep) begin
               errors++;
               $display("FAIL oneshot step c=%0d got %0d exp %0d", c, oSTEP, expStep);
            end
            checks++;
            if (oDONE !== (c == 16)) begin
               errors++;
               $display("FAIL oneshot done c=%0d got %b exp %b", c, oDONE, (c == 16));
            end
         end
         busyCnt += int'(oBUSY);
         doneCnt += int'(oDONE);
         @(negedge iCLK);
      end
      checks++;
      if (busyCnt != 16) begin
         errors++;
         $display("FAIL oneshot busy cycles got %0d exp 16", busyCnt);
      end
      checks++;
      if (doneCnt != 1) begin
         errors++;
         $display("FAIL oneshot done pulses got %0d exp 1", doneCnt);
      end
      $display("oneshot: busy cycles=%0d done pulses=%0d", busyCnt, doneCnt);
   endtask

   // Same table looped; iSTART held during PLAY must not restart; stop in step1.
   task automatic test_loop_stop();
      logic [0:15] snd;
      logic [1:0]  expStep;
      int p;
      snd = 16'b0001_1100_0000_0000;
      iLEN = 3'd3; iLOOP = 1'b1;
      startPulse();
      for (int c = 0; c < 26; c++) begin
         p = c % 16;
         expStep = (p < 8) ? 2'd0 : (p < 12) ? 2'd1 : 2'd2;
         checks++;
         if (oSTEP !== expStep || oSOUND !== snd[p] || oDONE !== 1'b0 || oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL loop c=%0d step/sound/done/busy got %0d/%b/%b/%b exp %0d/%b/0/1",
                     c, oSTEP, oSOUND, oDONE, oBUSY, expStep, snd[p]);
         end
         if (c == 3)  iSTART = 1'b1;
         if (c == 5)  iSTART = 1'b0;
         if (c == 25) iSTOP  = 1'b1;
         @(negedge iCLK);
      end
      iSTOP = 1'b0;
      checks++;
      if (oBUSY !== 1'b0 || oSOUND !== 1'b0 || oDONE !== 1'b0 || oSTEP !== 2'd1) begin
         errors++;
         $display("FAIL loop stop busy/sound/done/step got %b%b%b/%0d exp 000/1", oBUSY, oSOUND, oDONE, oSTEP);
      end
      $display("loop+stop: busy=%b sound=%b step=%0d", oBUSY, oSOUND, oSTEP);
   endtask

   task automatic test_start_stop_idle();
      iLEN = 3'd3; iLOOP = 1'b0;
      iSTART = 1'b1; iSTOP = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge iCLK);
         checks++;
         if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL start+stop idle c=%0d busy got %b exp 0", c, oBUSY);
         end
      end
      iSTART = 1'b0; iSTOP = 1'b0;
      $display("start+stop in idle: busy=%b", oBUSY);
   endtask

   task automatic test_bad_len();
      logic [2:0] lens [2];
      lens[0] = 3'd0;
      lens[1] = 3'd5;
      for (int k = 0; k < 2; k++) begin
         iLEN = lens[k];
         startPulse();
         for (int c = 0; c < 2; c++) begin
            checks++;
            if (oBUSY !== 1'b0) begin
               errors++;
               $display("FAIL bad len=%0d c=%0d busy got %b exp 0", lens[k], c, oBUSY);
            end
            @(negedge iCLK);
         end
         $display("bad len=%0d: busy=%b", lens[k], oBUSY);
      end
   endtask

   // Entry1 rewritten to DUR=0: step1 lasts exactly one tick.
   task automatic test_dur0();
      logic [1:0] expStep;
      writeNote(2'd1, 8'd0, 4'd0);
      iLEN = 3'd2; iLOOP = 1'b0;
      startPulse();
      for (int c = 0; c < 14; c++) begin
         expStep = (c < 8) ? 2'd0 : 2'd1;
         checks++;
         if (oBUSY !== (c < 12) || oDONE !== (c == 12) || oSTEP !== expStep) begin
            errors++;
            $display("FAIL dur0 c=%0d busy/done/step got %b/%b/%0d exp %b/%b/%0d",
                     c, oBUSY, oDONE, oSTEP, (c < 12), (c == 12), expStep);
         end
         @(negedge iCLK);
      end
      $display("dur0: step1 lasted 4 cycles, busy=%b", oBUSY);
   endtask

   // Rewrite of the playing entry HP 3->2, then stop while sound is high.
   task automatic test_hp_change();
      logic [0:15] snd;
      snd = 16'b0001_1001_0011_0011;
      iLEN = 3'd1; iLOOP = 1'b1;
      startPulse();
      for (int c = 0; c < 15; c++) begin
         checks++;
         if (oSOUND !== snd[c] || oSTEP !== 2'd0) begin
            errors++;
            $display("FAIL hpchange c=%0d sound/step got %b/%0d exp %b/0", c, oSOUND, oSTEP, snd[c]);
         end
         if (c == 3) begin
            iWR_EN = 1'b1; iWR_ADDR = 2'd0; iWR_HP = 8'd2; iWR_DUR = 4'd2;
         end
         if (c == 4)  iWR_EN = 1'b0;
         if (c == 14) iSTOP  = 1'b1;
         @(negedge iCLK);
      end
      iSTOP = 1'b0;
      checks++;
      if (oBUSY !== 1'b0 || oSOUND !== 1'b0 || oDONE !== 1'b0) begin
         errors++;
         $display("FAIL hpchange stop busy/sound/done got %b%b%b exp 000", oBUSY, oSOUND, oDONE);
      end
      $display("hpchange: interval 3->2, stop with sound high -> sound=%b", oSOUND);
      writeNote(2'd0, 8'd3, 4'd2);
      writeNote(2'd1, 8'd0, 4'd1);
   endtask

   // Asynchronous reset in step2, then the table must read back all zero.
   task automatic test_async_reset();
      logic [1:0] expStep;
      iLEN = 3'd3; iLOOP = 1'b0;
      startPulse();
      for (int c = 0; c < 13; c++) @(negedge iCLK);
      checks++;
      if (oSTEP !== 2'd2 || oBUSY !== 1'b1) begin
         errors++;
         $display("FAIL rst pre step/busy got %0d/%b exp 2/1", oSTEP, oBUSY);
      end
      #2;
      iRST = 1'b1;
      #1;
      checks++;
      if (oBUSY !== 1'b0 || oSOUND !== 1'b0 || oDONE !== 1'b0 || oSTEP !== 2'd0) begin
         errors++;
         $display("FAIL rst async busy/sound/done/step got %b%b%b/%0d exp 000/0", oBUSY, oSOUND, oDONE, oSTEP);
      end
      @(negedge iCLK);
      iRST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge iCLK);
         checks++;
         if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst no restart c=%0d busy got %b exp 0", c, oBUSY);
         end
      end
      iLEN = 3'd4; iLOOP = 1'b0;
      startPulse();
      for (int c = 0; c < 18; c++) begin
         expStep = (c < 16) ? 2'(c / 4) : 2'd3;
         checks++;
         if (oSOUND !== 1'b0 || oSTEP !== expStep || oBUSY !== (c < 16) || oDONE !== (c == 16)) begin
            errors++;
            $display("FAIL rst table c=%0d sound/step/busy/done got %b/%0d/%b/%b exp 0/%0d/%b/%b",
                     c, oSOUND, oSTEP, oBUSY, oDONE, expStep, (c < 16), (c == 16));
         end
         @(negedge iCLK);
      end
      $display("async reset: outputs cleared, zero table played silent 1-tick steps");
   endtask

   initial begin
      test_reset();
      writeNote(2'd0, 8'd3, 4'd2);
      writeNote(2'd1, 8'd0, 4'd1);
      writeNote(2'd2, 8'd5, 4'd1);
      writeNote(2'd3, 8'd2, 4'd1);
      test_oneshot();
      test_loop_stop();
      test_start_stop_idle();
      test_bad_len();
      test_dur0();
      test_hp_change();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
